// File: rtl/nmr_bstrm_simp_datapath.sv
// Pulse-generation datapath for the NMR bitstream sequencer: loads one command per
// START, holds the selected level on OUT for max(data,2) cycles and flags DPATH_RDY one cycle early.
module nmr_bstrm_simp_datapath #(
    parameter int DATA_WIDTH = 24,
    parameter int MUX_WIDTH  = 16,
    parameter int SEL_W      = $clog2(MUX_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    output logic                  DPATH_RDY,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  PLS_POL,
    input  logic [SEL_W-1:0]      mux_sel,
    input  logic [MUX_WIDTH-2:0]  mux_in,
    output logic                  OUT
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] CNT_MIN = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);
    localparam logic [SEL_W:0]        MUX_CNT = (SEL_W + 1)'(MUX_WIDTH);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    level_q, level_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [MUX_WIDTH-1:0]    mux_vec_s;

    // State register; reset aborts any pulse in progress
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state: START always wins, so a command in the final cycle chains with no gap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        sel_d   = sel_q;
        if (START) begin
            state_d = RUN;
            level_d = PLS_POL;
            sel_d   = mux_sel;
            if (data < CNT_MIN) begin
                cnt_d = CNT_MIN;
            end else begin
                cnt_d = data;
            end
        end else if (state_q == RUN) begin
            if (cnt_q > CNT_ONE) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
                sel_d   = '0;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // Ready strobe lands one cycle before the last pulse cycle
    always_comb begin
        DPATH_RDY = 1'b0;
        if ((state_q == RUN) && (cnt_q == CNT_MIN)) begin
            DPATH_RDY = 1'b1;
        end else begin
            DPATH_RDY = 1'b0;
        end
    end

    // Output mux: source 0 is the registered level, others are external inputs
    always_comb begin
        mux_vec_s = {mux_in, level_q};
        OUT       = 1'b0;
        if ({1'b0, sel_q} < MUX_CNT) begin
            OUT = mux_vec_s[sel_q];
        end else begin
            OUT = 1'b0;
        end
    end

endmodule

// File: tb/tb_nmr_bstrm_simp_datapath.sv
// Directed bench for nmr_bstrm_simp_datapath: pulse length, chaining, clamping,
// external mux sources, mid-pulse restart and asynchronous reset.
module tb_nmr_bstrm_simp_datapath;

    localparam int DW = 24;
    localparam int MW = 16;
    localparam int SW = 4;

    logic          CLK;
    logic          RST;
    logic          START;
    logic          DPATH_RDY;
    logic [DW-1:0] data;
    logic          PLS_POL;
    logic [SW-1:0] mux_sel;
    logic [MW-2:0] mux_in;
    logic          OUT;

    int checks = 0;
    int errors = 0;

    nmr_bstrm_simp_datapath #(.DATA_WIDTH(DW), .MUX_WIDTH(MW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .DPATH_RDY (DPATH_RDY),
        .data      (data),
        .PLS_POL   (PLS_POL),
        .mux_sel   (mux_sel),
        .mux_in    (mux_in),
        .OUT       (OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Present a command for one rising edge; returns in cycle 1 of the pulse
    task automatic issue(input int d, input logic pol, input int sel);
        START   = 1'b1;
        data    = DW'(d);
        PLS_POL = pol;
        mux_sel = SW'(sel);
        @(negedge CLK);
        START   = 1'b0;
    endtask

    // Check cycles 1..upto of an n-cycle pulse at level lvl; optionally chain a
    // new command during cycle upto.
    task automatic pulse(input int n, input logic lvl, input int upto,
                         input bit chain, input int nd, input logic npol, input int nsel);
        for (int i = 1; i <= upto; i++) begin
            check($sformatf("out_c%0d_of_%0d", i, n), OUT, lvl);
            check($sformatf("rdy_c%0d_of_%0d", i, n), DPATH_RDY, (i == n - 1) ? 1'b1 : 1'b0);
            if (chain && i == upto) begin
                START   = 1'b1;
                data    = DW'(nd);
                PLS_POL = npol;
                mux_sel = SW'(nsel);
            end
            @(negedge CLK);
        end
        START = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check({tag, "_out"}, OUT, 1'b0);
            check({tag, "_rdy"}, DPATH_RDY, 1'b0);
            @(negedge CLK);
        end
    endtask

    initial begin
        RST     = 1'b1;
        START   = 1'b0;
        data    = '0;
        PLS_POL = 1'b0;
        mux_sel = '0;
        mux_in  = '0;
        #1;
        check("reset_out", OUT, 1'b0);
        check("reset_rdy", DPATH_RDY, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        idle(2, "post_reset");

        // 100-cycle high pulse, ready in cycle 99, then idle
        issue(100, 1'b1, 0);
        pulse(100, 1'b1, 100, 1'b0, 0, 1'b0, 0);
        idle(4, "after_100");

        // Back-to-back: 10 high then 7 low, chained from the ready strobe
        issue(10, 1'b1, 0);
        pulse(10, 1'b1, 10, 1'b1, 7, 1'b0, 0);
        pulse(7, 1'b0, 7, 1'b0, 0, 1'b0, 0);
        idle(2, "after_chain");

        // Lengths 0 and 1 are clamped to 2
        issue(0, 1'b1, 0);
        pulse(2, 1'b1, 2, 1'b0, 0, 1'b0, 0);
        idle(2, "after_len0");
        issue(1, 1'b1, 0);
        pulse(2, 1'b1, 2, 1'b0, 0, 1'b0, 0);
        idle(2, "after_len1");

        // External source 3 -> mux_in[2]; level is ignored and toggles pass through
        mux_in = 15'h0004;
        issue(20, 1'b0, 3);
        for (int i = 1; i <= 20; i++) begin
            if (i == 11) mux_in = 15'h0000;
            if (i == 14) mux_in = 15'h0004;
            #1;
            check($sformatf("mux_out_c%0d", i), OUT, (i >= 11 && i < 14) ? 1'b0 : 1'b1);
            check($sformatf("mux_rdy_c%0d", i), DPATH_RDY, (i == 19) ? 1'b1 : 1'b0);
            @(negedge CLK);
        end
        idle(3, "after_mux");
        mux_in = '0;

        // Restart mid-pulse at cnt==30 with a 5-cycle low pulse
        issue(50, 1'b1, 0);
        pulse(50, 1'b1, 21, 1'b1, 5, 1'b0, 0);
        pulse(5, 1'b0, 5, 1'b0, 0, 1'b0, 0);
        idle(3, "after_restart");

        // Asynchronous reset between edges aborts the pulse immediately
        issue(40, 1'b1, 0);
        pulse(40, 1'b1, 5, 1'b0, 0, 1'b0, 0);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_out", OUT, 1'b0);
        check("async_rst_rdy", DPATH_RDY, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        idle(6, "after_async_rst");

        // Recovery after reset
        issue(3, 1'b1, 0);
        pulse(3, 1'b1, 3, 1'b0, 0, 1'b0, 0);
        idle(2, "after_recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmr_bstrm_simp_datapath.md
Name: nmr_bstrm_simp_datapath

Overview:
Pulse-generation datapath of the NMR bitstream sequencer. Each START loads one command: pulse length, polarity and output mux select. The block drives OUT at that level for exactly `data` clock cycles. One cycle-accurate DPATH_RDY strobe lets the sequencer controller issue the next command, so consecutive pulses join with no gap or overlap.

Parameters:
DATA_WIDTH, 24, width of pulse-length input and internal down-counter
MUX_WIDTH, 16, number of output mux sources; select width is clog2(MUX_WIDTH) (4 by default)

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  reset, asynchronous, active-high
START  input  1  one-cycle command strobe; sampled on rising CLK
DPATH_RDY  output  1  one-cycle strobe: accept next START one cycle later
data  input  DATA_WIDTH  pulse length in clock cycles, unsigned
PLS_POL  input  1  pulse level (1 = high, 0 = low)
mux_sel  input  clog2(MUX_WIDTH)  output source select
mux_in  input  MUX_WIDTH-1  external sources 1..MUX_WIDTH-1
OUT  output  1  bitstream output

Behaviour:
- Registers: level_r (1b), sel_r, cnt (DATA_WIDTH), busy flag. States: IDLE, RUN.
- Reset (async, any time, including mid-pulse): IDLE, cnt=0, level_r=0, sel_r=0, DPATH_RDY=0, OUT=0 (when mux_in[...] not selected). Any pulse in progress is aborted.
- Load on a rising edge where START=1, regardless of state (IDLE or RUN, any cnt): level_r<=PLS_POL, sel_r<=mux_sel, cnt<=max(data,2), state<=RUN.
  - data values 0 and 1 are clamped to 2.
  - START in RUN restarts the pulse with the new command (normal back-to-back case when it coincides with cnt==1).
- RUN without START: cnt<=cnt-1 each edge while cnt>1.
  - At an edge with cnt==1 and START=0: state<=IDLE, level_r<=0, sel_r<=0.
- Pulse duration: level is valid on OUT for exactly N=max(data,2) cycles, from the edge that sampled START through the cycle in which cnt==1.
- DPATH_RDY: combinational decode, high exactly during the single cycle when state==RUN and cnt==2. It is low in IDLE and low when cnt≠2.
  - A controller that registers START from DPATH_RDY presents START during the cnt==1 cycle. The next pulse then starts on the following edge with zero gap.
- OUT mux, combinational from registered values:
  - sel_r==0: OUT = level_r.
  - sel_r==k, 1≤k≤MUX_WIDTH-1: OUT = mux_in[k-1].
  - DPATH_RDY and counting are identical for all sel_r.
- Latency: START sampled at edge E gives the new OUT level in the cycle after E. There is no extra pipeline.
- Glitch-free for sel_r==0 (OUT driven directly from a flop). No output is undefined after reset.
- Controller minimum pulse length is 7 cycles due to its own turnaround. The datapath itself supports N≥2.

Test Plan:
- Reset then START with data=100, PLS_POL=1, mux_sel=0 -> OUT=1 for exactly 100 cycles, DPATH_RDY high only in cycle 99. No further START -> OUT=0, DPATH_RDY stays 0.
- START data=10 pol=1, then START driven in the cycle after DPATH_RDY with data=7 pol=0 -> OUT high 10 cycles then low 7 cycles with zero gap; DPATH_RDY at cycles 9 and 16.
- START with data=0 and with data=1 -> each treated as 2-cycle pulse; DPATH_RDY asserted in the first cycle of the pulse.
- mux_sel=3, mux_in=15'h0004, data=20 -> OUT=1 (mux_in[2]) for 20 cycles regardless of PLS_POL. Toggling mux_in[2] mid-pulse follows on OUT combinationally. After expiry OUT=level_r=0.
- START mid-pulse (cnt=30 of data=50) with data=5 -> pulse restarts, OUT at new level for 5 cycles, DPATH_RDY at its 4th cycle.
- Assert RST mid-pulse (async, between edges) -> OUT=0 and DPATH_RDY=0 immediately. After release, block stays idle until the next START.
